instr_reg_sched: RTL

Write-arbitration and read-sequencing controller for the 32-entry instruction register.
- Accepts instructions (opcode, operand_a, operand_b) from two requesters through valid/ready handshakes, using round-robin arbitration.
- Allocates register slots as a circular buffer and drives the register's load_en, write_pointer, operand and opcode inputs.
- Reads entries back in write order through read_pointer and presents the stored instruction word (including the computed result) to a downstream consumer through a one-entry valid/ready output stage.

---
 rtl/instr_reg_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_reg_sched.sv
// Write-arbitration and read-sequencing controller for a circular instruction register.
// Two round-robin requesters fill the register; entries drain in order through a one-entry output stage.
module instr_reg_sched #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int OP_W  = 32,
   parameter int OPC_W = 4,
   parameter int IW_W  = 2*OP_W+OPC_W+64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req0_valid,
   input  logic                   req1_valid,
   output logic                   req0_ready,
   output logic                   req1_ready,
   input  logic signed [OP_W-1:0] req0_opa,
   input  logic signed [OP_W-1:0] req1_opa,
   input  logic signed [OP_W-1:0] req0_opb,
   input  logic signed [OP_W-1:0] req1_opb,
   input  logic [OPC_W-1:0]       req0_opc,
   input  logic [OPC_W-1:0]       req1_opc,
   output logic                   load_en,
   output logic [AW-1:0]          write_pointer,
   output logic signed [OP_W-1:0] operand_a,
   output logic signed [OP_W-1:0] operand_b,
   output logic [OPC_W-1:0]       opcode,
   output logic [AW-1:0]          read_pointer,
   input  logic [IW_W-1:0]        instruction_word,
   output logic                   cons_valid,
   input  logic                   cons_ready,
   output logic [IW_W-1:0]        cons_iw,
   output logic [AW:0]            count,
   output logic                   full,
   output logic                   empty
);

   logic                   load_en_q, load_en_d;
   logic [AW-1:0]          wp_q, wp_d;
   logic signed [OP_W-1:0] opa_q, opa_d;
   logic signed [OP_W-1:0] opb_q, opb_d;
   logic [OPC_W-1:0]       opc_q, opc_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic                   last_grant_q, last_grant_d;   // 1: req1 was granted last
   logic                   cons_valid_q, cons_valid_d;
   logic [IW_W-1:0]        cons_iw_q, cons_iw_d;

   logic       grant0, grant1, accept, pop;
   logic [AW+1:0] fill;

   // Fill counts the write still in flight so a slot is never handed out twice.
   assign fill  = {1'b0, count_q} + (AW+2)'(load_en_q);
   assign full  = (fill == (AW+2)'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      load_en_d    = 1'b0;
      wp_d         = wp_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      opc_d        = opc_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      last_grant_d = last_grant_q;
      cons_valid_d = cons_valid_q;
      cons_iw_d    = cons_iw_q;

      grant0     = req0_valid & (~req1_valid | last_grant_q);
      grant1     = req1_valid & (~req0_valid | ~last_grant_q);
      req0_ready = grant0 & ~full & reset_n;
      req1_ready = grant1 & ~full & reset_n;
      accept     = req0_ready | req1_ready;
      pop        = (count_q != '0) & (~cons_valid_q | cons_ready);

      if (accept) begin
         load_en_d    = 1'b1;
         wp_d         = wr_ptr_q;
         wr_ptr_d     = wr_ptr_q + AW'(1);
         last_grant_d = req1_ready;
         opa_d        = req1_ready ? req1_opa : req0_opa;
         opb_d        = req1_ready ? req1_opb : req0_opb;
         opc_d        = req1_ready ? req1_opc : req0_opc;
      end

      if (pop) begin
         cons_iw_d    = instruction_word;
         cons_valid_d = 1'b1;
         rd_ptr_d     = rd_ptr_q + AW'(1);
      end else if (cons_ready) begin
         cons_valid_d = 1'b0;
      end

      case ({load_en_q, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         load_en_q    <= 1'b0;
         wp_q         <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         opc_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= 1'b1;
         cons_valid_q <= 1'b0;
         cons_iw_q    <= '0;
      end else begin
         load_en_q    <= load_en_d;
         wp_q         <= wp_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         opc_q        <= opc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
         cons_valid_q <= cons_valid_d;
         cons_iw_q    <= cons_iw_d;
      end
   end

   assign load_en       = load_en_q;
   assign write_pointer = wp_q;
   assign operand_a     = opa_q;
   assign operand_b     = opb_q;
   assign opcode        = opc_q;
   assign read_pointer  = rd_ptr_q;
   assign cons_valid    = cons_valid_q;
   assign cons_iw       = cons_iw_q;
   assign count         = count_q;

endmodule
